// File: rtl/muldiv_unit_pkg.sv
// muldiv_unit_pkg: ALU control codes and muldiv FSM states shared by the CPU, ALU decoder and muldiv unit
package muldiv_unit_pkg;
  localparam logic [4:0] ALU_MULTU = 5'b00111;
  localparam logic [4:0] ALU_MULT  = 5'b01000;
  localparam logic [4:0] ALU_DIV   = 5'b01111;
  localparam logic [4:0] ALU_DIVU  = 5'b10000;
  localparam logic [4:0] ALU_MTHI  = 5'b10001;
  localparam logic [4:0] ALU_MTLO  = 5'b10010;
  typedef enum logic [1:0] {IDLE, RUN, FIX} md_state_e;
endpackage

// File: rtl/muldiv_negate.sv
// muldiv_negate: conditional two's-complement negation
module muldiv_negate #(
  parameter int WIDTH = 32
) (
  input  logic [WIDTH-1:0] a,
  input  logic             neg,
  output logic [WIDTH-1:0] y
);
  assign y = neg ? -a : a;
endmodule

// File: rtl/muldiv_unit.sv
// muldiv_unit: iterative MIPS-style multiply/divide unit with HI/LO registers
module muldiv_unit
  import muldiv_unit_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int OPW   = 5
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [OPW-1:0]   alucontrol,
  input  logic [WIDTH-1:0] srca,
  input  logic [WIDTH-1:0] srcb,
  input  logic             abort,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo
);
  localparam int CW = $clog2(WIDTH);
  md_state_e            state;
  logic [CW-1:0]        cnt;
  logic [WIDTH-1:0]     opb;
  logic [2*WIDTH-1:0]   acc;
  logic                 is_div, neg_a, neg_b, divz;
  logic                 op_mult, op_multu, op_div, op_divu, op_mthi, op_mtlo, op_iter, op_signed;
  logic [WIDTH-1:0]     abs_a, abs_b, quo, rem;
  logic [2*WIDTH-1:0]   prod, step;
  logic [WIDTH:0]       psum, tmp, diff;
  assign op_mult   = alucontrol == OPW'(ALU_MULT);
  assign op_multu  = alucontrol == OPW'(ALU_MULTU);
  assign op_div    = alucontrol == OPW'(ALU_DIV);
  assign op_divu   = alucontrol == OPW'(ALU_DIVU);
  assign op_mthi   = alucontrol == OPW'(ALU_MTHI);
  assign op_mtlo   = alucontrol == OPW'(ALU_MTLO);
  assign op_signed = op_mult | op_div;
  assign op_iter   = op_mult | op_multu | op_div | op_divu;
  muldiv_negate #(.WIDTH(WIDTH)) u_abs_a (.a(srca), .neg(op_signed & srca[WIDTH-1]), .y(abs_a));
  muldiv_negate #(.WIDTH(WIDTH)) u_abs_b (.a(srcb), .neg(op_signed & srcb[WIDTH-1]), .y(abs_b));
  // Multiplier/dividend magnitude lives in acc's low half; opb holds multiplicand/divisor.
  assign psum = {1'b0, acc[2*WIDTH-1:WIDTH]} + (acc[0] ? {1'b0, opb} : '0);
  assign tmp  = {acc[2*WIDTH-1:WIDTH], acc[WIDTH-1]};
  // diff[WIDTH] is set exactly when the trial subtraction borrows, since rem < divisor.
  assign diff = tmp - {1'b0, opb};
  assign step = is_div ? {diff[WIDTH] ? tmp[WIDTH-1:0] : diff[WIDTH-1:0], acc[WIDTH-2:0], ~diff[WIDTH]}
                       : {psum, acc[WIDTH-1:1]};
  muldiv_negate #(.WIDTH(2*WIDTH)) u_fix_p (.a(acc), .neg(neg_a ^ neg_b), .y(prod));
  muldiv_negate #(.WIDTH(WIDTH)) u_fix_q (.a(acc[WIDTH-1:0]), .neg(neg_a ^ neg_b), .y(quo));
  muldiv_negate #(.WIDTH(WIDTH)) u_fix_r (.a(acc[2*WIDTH-1:WIDTH]), .neg(neg_a), .y(rem));
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state  <= IDLE;
      cnt    <= '0;
      opb    <= '0;
      acc    <= '0;
      is_div <= 1'b0;
      neg_a  <= 1'b0;
      neg_b  <= 1'b0;
      divz   <= 1'b0;
      busy   <= 1'b0;
      done   <= 1'b0;
      hi     <= '0;
      lo     <= '0;
    end else begin
      done <= 1'b0;
      if (state == IDLE) begin
        if (start && !abort) begin
          if (op_iter) begin
            state  <= RUN;
            busy   <= 1'b1;
            cnt    <= '0;
            opb    <= abs_b;
            acc    <= {{WIDTH{1'b0}}, abs_a};
            is_div <= op_div | op_divu;
            neg_a  <= op_signed & srca[WIDTH-1];
            neg_b  <= op_signed & srcb[WIDTH-1];
            divz   <= srcb == '0;
          end
          if (op_mthi) hi <= srca;
          if (op_mtlo) lo <= srca;
        end
      end else if (abort) begin
        state <= IDLE;
        busy  <= 1'b0;
      end else if (state == RUN) begin
        acc <= step;
        cnt <= cnt + 1'b1;
        if (cnt == CW'(WIDTH - 1)) state <= FIX;
      end else begin
        state <= IDLE;
        busy  <= 1'b0;
        done  <= 1'b1;
        hi    <= is_div ? rem : prod[2*WIDTH-1:WIDTH];
        lo    <= is_div ? (divz ? '1 : quo) : prod[WIDTH-1:0];
      end
    end
  end
endmodule

// File: tb/tb_muldiv_unit.sv
// tb_muldiv_unit: randomized and directed checks of muldiv_unit against an arithmetic reference model
module tb_muldiv_unit;
  import muldiv_unit_pkg::*;
  logic        clk, rst_n, start, abort, busy, done;
  logic [4:0]  alucontrol;
  logic [31:0] srca, srcb, hi, lo;
  logic [31:0] exp_hi, exp_lo;
  int checks, failures;

  muldiv_unit #(.WIDTH(32), .OPW(5)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .alucontrol(alucontrol),
    .srca(srca), .srcb(srcb), .abort(abort), .busy(busy), .done(done),
    .hi(hi), .lo(lo)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [63:0] model(input logic [4:0] op, input logic [31:0] a, input logic [31:0] b);
    longint sa, sb, q, r;
    longint unsigned ua, ub;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    ua = {32'b0, a};
    ub = {32'b0, b};
    if (op == ALU_MULT) return 64'(sa * sb);
    if (op == ALU_MULTU) return 64'(ua * ub);
    if (b == 32'd0) return {a, 32'hFFFF_FFFF};
    if (op == ALU_DIVU) return {32'(ua % ub), 32'(ua / ub)};
    if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return {32'd0, 32'h8000_0000};
    q = sa / sb;
    r = sa % sb;
    return {r[31:0], q[31:0]};
  endfunction

  function automatic logic [31:0] rnd_opnd();
    case ($urandom_range(0, 6))
      0: return 32'd0;
      1: return 32'h8000_0000;
      2: return 32'hFFFF_FFFF;
      3: return 32'd1;
      default: return $urandom();
    endcase
  endfunction

  task automatic do_op(input logic [4:0] op, input logic [31:0] a, input logic [31:0] b, output int lat);
    @(negedge clk);
    start = 1'b1; alucontrol = op; srca = a; srcb = b;
    @(posedge clk); #1;
    start = 1'b0;
    lat = 1;
    while (!done && lat < 100) begin
      @(posedge clk); #1;
      lat++;
    end
    {exp_hi, exp_lo} = model(op, a, b);
  endtask

  task automatic test_reset();
    #1;
    checks++;
    if (busy !== 1'b0 || done !== 1'b0 || hi !== 32'd0 || lo !== 32'd0) begin
      failures++;
      $display("FAIL reset busy=%b done=%b hi=%h lo=%h required 0 0 0 0", busy, done, hi, lo);
    end
    exp_hi = 0; exp_lo = 0;
    @(negedge clk); rst_n = 1'b1;
  endtask

  task automatic test_directed();
    logic [4:0]  ops [4] = '{ALU_MULT, ALU_DIVU, ALU_DIV, ALU_DIV};
    logic [31:0] as  [4] = '{32'hFFFF_FFFD, 32'd100, 32'hFFFF_FFF9, 32'd5};
    logic [31:0] bs  [4] = '{32'd7, 32'd7, 32'd2, 32'd0};
    logic [31:0] his [4] = '{32'hFFFF_FFFF, 32'd2, 32'hFFFF_FFFF, 32'd5};
    logic [31:0] los [4] = '{32'hFFFF_FFEB, 32'd14, 32'hFFFF_FFFD, 32'hFFFF_FFFF};
    int lat;
    for (int i = 0; i < 4; i++) begin
      do_op(ops[i], as[i], bs[i], lat);
      checks++;
      if (lat !== 34 || hi !== his[i] || lo !== los[i]) begin
        failures++;
        $display("FAIL directed%0d lat=%0d hi=%h lo=%h required lat=34 hi=%h lo=%h", i, lat, hi, lo, his[i], los[i]);
      end
      @(posedge clk); #1;
      checks++;
      if (done !== 1'b0 || busy !== 1'b0) begin
        failures++;
        $display("FAIL done_pulse%0d done=%b busy=%b required 0 0", i, done, busy);
      end
    end
  endtask

  task automatic test_random();
    logic [4:0] codes [4] = '{ALU_MULT, ALU_MULTU, ALU_DIV, ALU_DIVU};
    logic [4:0] op;
    logic [31:0] a, b;
    int lat;
    for (int i = 0; i < 40; i++) begin
      op = codes[$urandom_range(0, 3)];
      a = rnd_opnd();
      b = rnd_opnd();
      do_op(op, a, b, lat);
      checks++;
      if (lat !== 34 || hi !== exp_hi || lo !== exp_lo) begin
        failures++;
        $display("FAIL random op=%b a=%h b=%h lat=%0d hi=%h lo=%h required lat=34 hi=%h lo=%h",
                 op, a, b, lat, hi, lo, exp_hi, exp_lo);
      end
    end
  endtask

  task automatic test_abort();
    int lat;
    logic [31:0] ph, pl;
    ph = exp_hi; pl = exp_lo;
    @(negedge clk);
    start = 1'b1; alucontrol = ALU_MULTU; srca = 32'h1234_5678; srcb = 32'h9ABC_DEF0;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (9) @(posedge clk);
    @(negedge clk); abort = 1'b1;
    @(posedge clk); #1;
    abort = 1'b0;
    checks++;
    if (busy !== 1'b0 || done !== 1'b0 || hi !== ph || lo !== pl) begin
      failures++;
      $display("FAIL abort busy=%b done=%b hi=%h lo=%h required 0 0 %h %h", busy, done, hi, lo, ph, pl);
    end
    do_op(ALU_MULT, 32'hFFFF_FFFF, 32'hFFFF_FFFF, lat);
    checks++;
    if (lat !== 34 || hi !== 32'd0 || lo !== 32'd1) begin
      failures++;
      $display("FAIL after_abort lat=%0d hi=%h lo=%h required lat=34 hi=0 lo=1", lat, hi, lo);
    end
  endtask

  task automatic test_mthi_busy();
    int lat;
    @(negedge clk);
    start = 1'b1; alucontrol = ALU_MTHI; srca = 32'h1234_5678;
    @(posedge clk); #1;
    start = 1'b0;
    checks++;
    if (hi !== 32'h1234_5678 || busy !== 1'b0 || done !== 1'b0 || lo !== exp_lo) begin
      failures++;
      $display("FAIL mthi hi=%h lo=%h busy=%b done=%b required 12345678 %h 0 0", hi, lo, busy, done, exp_lo);
    end
    @(negedge clk);
    start = 1'b1; alucontrol = ALU_MTLO; srca = 32'hCAFE_F00D;
    @(posedge clk); #1;
    start = 1'b0;
    checks++;
    if (lo !== 32'hCAFE_F00D || hi !== 32'h1234_5678 || busy !== 1'b0) begin
      failures++;
      $display("FAIL mtlo lo=%h hi=%h busy=%b required cafef00d 12345678 0", lo, hi, busy);
    end
    @(negedge clk);
    start = 1'b1; alucontrol = ALU_MULT; srca = 32'd6; srcb = 32'd7;
    @(posedge clk); #1;
    lat = 1;
    alucontrol = ALU_MTHI; srca = 32'hDEAD_BEEF;
    @(posedge clk); #1;
    lat++;
    alucontrol = ALU_DIVU; srca = 32'd99; srcb = 32'd3;
    @(posedge clk); #1;
    lat++;
    start = 1'b0;
    checks++;
    if (hi !== 32'h1234_5678 || lo !== 32'hCAFE_F00D || busy !== 1'b1) begin
      failures++;
      $display("FAIL busy_ignore hi=%h lo=%h busy=%b required 12345678 cafef00d 1", hi, lo, busy);
    end
    while (!done && lat < 100) begin
      @(posedge clk); #1;
      lat++;
    end
    checks++;
    if (lat !== 34 || hi !== 32'd0 || lo !== 32'd42) begin
      failures++;
      $display("FAIL busy_result lat=%0d hi=%h lo=%h required lat=34 hi=0 lo=2a", lat, hi, lo);
    end
    exp_hi = 32'd0; exp_lo = 32'd42;
  endtask

  task automatic test_reset_mid();
    int lat;
    @(negedge clk);
    start = 1'b1; alucontrol = ALU_DIV; srca = 32'hFFFF_FF00; srcb = 32'd3;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (5) @(posedge clk);
    #2 rst_n = 1'b0;
    #1;
    checks++;
    if (busy !== 1'b0 || done !== 1'b0 || hi !== 32'd0 || lo !== 32'd0) begin
      failures++;
      $display("FAIL reset_mid busy=%b done=%b hi=%h lo=%h required 0 0 0 0", busy, done, hi, lo);
    end
    @(negedge clk); rst_n = 1'b1;
    do_op(ALU_DIVU, 32'd1000, 32'd33, lat);
    checks++;
    if (lat !== 34 || hi !== 32'd10 || lo !== 32'd30) begin
      failures++;
      $display("FAIL after_reset lat=%0d hi=%h lo=%h required lat=34 hi=a lo=1e", lat, hi, lo);
    end
  endtask

  task automatic test_back_to_back();
    logic [31:0] a, b;
    int lat;
    for (int i = 0; i < 4; i++) begin
      a = $urandom();
      b = $urandom_range(1, 1000);
      do_op(i[0] ? ALU_DIV : ALU_MULTU, a, b, lat);
      checks++;
      if (lat !== 34 || hi !== exp_hi || lo !== exp_lo) begin
        failures++;
        $display("FAIL back_to_back%0d lat=%0d hi=%h lo=%h required lat=34 hi=%h lo=%h", i, lat, hi, lo, exp_hi, exp_lo);
      end
    end
  endtask

  initial begin
    checks = 0; failures = 0;
    rst_n = 1'b0; start = 1'b0; abort = 1'b0;
    alucontrol = 5'd0; srca = 32'd0; srcb = 32'd0;
    test_reset();
    test_directed();
    test_random();
    test_abort();
    test_mthi_busy();
    test_reset_mid();
    test_back_to_back();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
